// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter slice.
// Arbitration mode follows the SRAM_ARB_RR_EN macro: defined selects
// round-robin, undefined selects fixed priority (lowest index wins).
package sram_arb_pkg;

    localparam int MaxN = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int IdxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Route FIFO entry: requester index, sized for the largest supported N.
    typedef logic [$clog2(MaxN)-1:0] route_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

`ifdef SRAM_ARB_RR_EN
    localparam arb_mode_e ArbMode = ARB_RR;
`else
    localparam arb_mode_e ArbMode = ARB_FIXED;
`endif

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with combinational head read. Pass=1 lets a write fall
// through to the read side while the FIFO is empty.
module fifo_sync #(
    parameter int Width = 1,
    parameter int Depth = 2,
    parameter int Pass  = 0,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wvalid,
    input  logic [Width-1:0] wdata,
    input  logic             rready,
    output logic             rvalid,
    output logic [Width-1:0] rdata,
    output logic [CntW-1:0]  count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]  count_reg;
    logic             empty, full, push, pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CntW'(Depth));
    assign count = count_reg;

    if (Pass != 0) begin : g_pass
        assign rvalid = ~empty | wvalid;
        assign rdata  = empty ? wdata : mem[rd_ptr_reg];
        assign push   = wvalid & ~full & ~(empty & rready);
        assign pop    = rready & ~empty;
    end else begin : g_nopass
        assign rvalid = ~empty;
        assign rdata  = mem[rd_ptr_reg];
        assign push   = wvalid & ~full;
        assign pop    = rready & ~empty;
    end

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap modulo Depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: rtl/sram_arb_rr.sv
// Combinational rotating-priority picker. With en=1 the search starts at ptr
// and wraps; with en=0 it starts at index 0 (plain fixed priority).
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         elig,
    input  logic [IdxW(N)-1:0]   ptr,
    input  logic                 en,
    output logic [N-1:0]         winner_oh,
    output logic [IdxW(N)-1:0]   winner_idx,
    output logic                 valid
);

    localparam int IW = IdxW(N);

    // Scan N positions starting at the base; the first eligible one wins.
    always_comb begin
        int base;
        int idx;
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        base       = en ? int'(ptr) : 0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (base + k >= N) ? (base + k - N) : (base + k);
            if (!valid && elig[idx]) begin
                valid          = 1'b1;
                winner_oh[idx] = 1'b1;
                winner_idx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// N-to-1 arbiter for a single-ported SRAM. Reads are tracked in an in-order
// route FIFO so each rvalid_i is steered back to the requester that issued it.
// Define SRAM_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 highest).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N           = 2,
    parameter int SramAw      = 12,
    parameter int SramDw      = 32,
    parameter int Outstanding = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           req_i,
    output logic [N-1:0]           gnt_o,
    input  logic [N-1:0]           we_i,
    input  logic [N*SramAw-1:0]    addr_i,
    input  logic [N*SramDw-1:0]    wdata_i,
    input  logic [N*SramDw-1:0]    wmask_i,
    output logic [SramDw-1:0]      rdata_o,
    output logic [N-1:0]           rvalid_o,
    output logic [1:0]             rerror_o,
    output logic                   req_o,
    output logic                   we_o,
    output logic [SramAw-1:0]      addr_o,
    output logic [SramDw-1:0]      wdata_o,
    output logic [SramDw-1:0]      wmask_o,
    input  logic                   gnt_i,
    input  logic [SramDw-1:0]      rdata_i,
    input  logic                   rvalid_i,
    input  logic [1:0]             rerror_i,
    output logic                   err_o
);

    localparam int IW   = IdxW(N);
    localparam int CntW = $clog2(Outstanding + 1);

    logic [CntW-1:0]             count;
    logic                        full, empty, fifo_rvalid;
    logic [N-1:0]                elig, winner_oh;
    logic [IW-1:0]               winner_idx, head, rr_ptr;
    logic                        winner_valid, rr_en;
    logic                        sram_ack, push, pop;
    logic                        err_reg;
    route_t                      head_route;
    logic [N-1:0][SramAw-1:0]    addr_lane;
    logic [N-1:0][SramDw-1:0]    wdata_lane, wmask_lane;

    // Reads are held off once the route FIFO is full; writes never need a slot.
    assign full  = (count == CntW'(Outstanding));
    assign empty = ~fifo_rvalid;
    assign elig  = req_i & (we_i | {N{~full}});

    sram_arb_rr #(.N(N)) u_pick (
        .elig       (elig),
        .ptr        (rr_ptr),
        .en         (rr_en),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx),
        .valid      (winner_valid)
    );

    assign req_o    = winner_valid;
    assign we_o     = |(we_i & winner_oh);
    assign sram_ack = req_o & gnt_i;
    assign push     = sram_ack & ~we_o;
    assign pop      = rvalid_i & ~empty;

    assign rdata_o  = rdata_i;
    assign rerror_o = rerror_i;
    assign err_o    = err_reg;

    assign head_route = route_t'(head);

    // Per-lane gating of the winner's request fields, grant and read return.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_lane
        assign addr_lane[gi]  = winner_oh[gi] ? addr_i[gi*SramAw +: SramAw]  : '0;
        assign wdata_lane[gi] = winner_oh[gi] ? wdata_i[gi*SramDw +: SramDw] : '0;
        assign wmask_lane[gi] = winner_oh[gi] ? wmask_i[gi*SramDw +: SramDw] : '0;
        assign gnt_o[gi]      = winner_oh[gi] & sram_ack;
        assign rvalid_o[gi]   = pop & (head_route == route_t'(gi));
    end

    // OR-reduce the gated lanes; all zero when nobody wins.
    always_comb begin
        addr_o  = '0;
        wdata_o = '0;
        wmask_o = '0;
        for (int i = 0; i < N; i++) begin
            addr_o  = addr_o  | addr_lane[i];
            wdata_o = wdata_o | wdata_lane[i];
            wmask_o = wmask_o | wmask_lane[i];
        end
    end

`ifdef SRAM_ARB_RR_EN
    logic [IW-1:0] ptr_reg;

    // Priority pointer moves just past the winner on every accepted request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
        end else if (sram_ack) begin
            ptr_reg <= (winner_idx == IW'(N - 1)) ? '0 : winner_idx + 1'b1;
        end
    end

    assign rr_ptr = ptr_reg;
    assign rr_en  = 1'b1;
`else
    assign rr_ptr = '0;
    assign rr_en  = 1'b0;
`endif

    fifo_sync #(
        .Width (IW),
        .Depth (Outstanding),
        .Pass  (0)
    ) u_route (
        .clock  (clock),
        .reset  (reset),
        .wvalid (push),
        .wdata  (winner_idx),
        .rready (rvalid_i),
        .rvalid (fifo_rvalid),
        .rdata  (head),
        .count  (count)
    );

    // Sticky flag for a read return that has no matching request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (rvalid_i && empty) begin
            err_reg <= 1'b1;
        end
    end

    a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(gnt_o));
    a_fixed_lowest: assert property (@(posedge clock) disable iff (!reset)
        (ArbMode == ARB_RR) || (elig == '0) || (winner_oh == (elig & (~elig + 1'b1))));

endmodule
